tpumac: RTL and testbench

TPUMAC -- requirements
Module: tpumac

---
 rtl/tpumac.sv | 83 ++++++++
 tb/tb_tpumac.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tpumac.sv
// ----------------------------------------------------------------------------
// tpumac -- systolic multiply-accumulate cell
//
// One processing element of a systolic array. The A and B operands are
// registered and passed on unchanged to the next cell, while the C register
// either loads a preset value or accumulates the signed product of the
// current operand inputs.
//
// Parameters
//   BITS_AB  width of the signed A/B operands (two's complement)
//   BITS_C   width of the signed accumulator (normally >= 2*BITS_AB)
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset; clears A, B and C
//   en     in   global register enable; 0 holds every register
//   WrEn   in   1 = load Cin into C, 0 = C <= Ain*Bin + C
//   Ain    in   signed A operand
//   Bin    in   signed B operand
//   Cin    in   signed accumulator preset value
//   Aout   out  registered copy of Ain
//   Bout   out  registered copy of Bin
//   Cout   out  registered accumulator value
// ----------------------------------------------------------------------------
module tpumac #(
   parameter int unsigned BITS_AB = 8,
   parameter int unsigned BITS_C  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      WrEn,
   input  logic signed [BITS_AB-1:0] Ain,
   input  logic signed [BITS_AB-1:0] Bin,
   input  logic signed [BITS_C-1:0]  Cin,
   output logic signed [BITS_AB-1:0] Aout,
   output logic signed [BITS_AB-1:0] Bout,
   output logic signed [BITS_C-1:0]  Cout
);

   localparam int unsigned PROD_W = 2 * BITS_AB;

   logic signed [BITS_AB-1:0] a_q;
   logic signed [BITS_AB-1:0] b_q;
   logic signed [BITS_C-1:0]  c_q;
   logic signed [BITS_C-1:0]  c_d;

   logic signed [PROD_W-1:0]  a_ext;
   logic signed [PROD_W-1:0]  b_ext;
   logic signed [PROD_W-1:0]  prod;
   logic signed [BITS_C-1:0]  prod_ext;
   logic signed [BITS_C-1:0]  sum;

   // The product uses the live operand inputs rather than the A/B registers,
   // so a cell accumulates in the same cycle its operands arrive.
   always_comb begin
      a_ext    = PROD_W'(Ain);
      b_ext    = PROD_W'(Bin);
      prod     = a_ext * b_ext;
      // Signed size cast sign-extends the full product to the accumulator width.
      prod_ext = BITS_C'(prod);
      // Plain truncating add: two's-complement wrap, no saturation.
      sum      = prod_ext + c_q;
      c_d      = WrEn ? Cin : sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         c_q <= '0;
      end else if (en) begin
         a_q <= Ain;
         b_q <= Bin;
         c_q <= c_d;
      end
   end

   assign Aout = a_q;
   assign Bout = b_q;
   assign Cout = c_q;

endmodule

// File: tb/tb_tpumac.sv
module tb_tpumac;

   localparam int unsigned BITS_AB = 8;
   localparam int unsigned BITS_C  = 16;

   logic                      clk   = 1'b0;
   logic                      rst_n = 1'b1;
   logic                      en    = 1'b0;
   logic                      WrEn  = 1'b0;
   logic signed [BITS_AB-1:0] Ain   = '0;
   logic signed [BITS_AB-1:0] Bin   = '0;
   logic signed [BITS_C-1:0]  Cin   = '0;
   logic signed [BITS_AB-1:0] Aout;
   logic signed [BITS_AB-1:0] Bout;
   logic signed [BITS_C-1:0]  Cout;

   tpumac #(
      .BITS_AB(BITS_AB),
      .BITS_C (BITS_C)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .WrEn (WrEn),
      .Ain  (Ain),
      .Bin  (Bin),
      .Cin  (Cin),
      .Aout (Aout),
      .Bout (Bout),
      .Cout (Cout)
   );

   always #5 clk = ~clk;

   typedef struct {
      string                     tag;
      logic signed [BITS_AB-1:0] a;
      logic signed [BITS_AB-1:0] b;
      logic signed [BITS_C-1:0]  c;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   task automatic drive(input logic e, input logic w, input int a, input int b, input int c);
      en   = e;
      WrEn = w;
      Ain  = 8'(a);
      Bin  = 8'(b);
      Cin  = 16'(c);
   endtask

   // Expected outputs after the next rising edge; c is wrapped to 16 bits here.
   task automatic push(input string tag, input int a, input int b, input int c);
      exp_t x;
      x.tag = tag;
      x.a   = 8'(a);
      x.b   = 8'(b);
      x.c   = 16'(c);
      sb.push_back(x);
   endtask

   task automatic tick;
      exp_t x;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL scoreboard: observed empty queue expected an entry");
      end else begin
         x = sb.pop_front();
         check({x.tag, "/Aout"}, 16'(Aout), 16'(x.a));
         check({x.tag, "/Bout"}, 16'(Bout), 16'(x.b));
         check({x.tag, "/Cout"}, 16'(Cout), 16'(x.c));
      end
   endtask

   initial begin
      int ai;
      int bi;
      int ci;

      // Reset state, then edges during reset are ignored
      #1 rst_n = 1'b0;
      #1;
      check("reset/Aout", 16'(Aout), 16'd0);
      check("reset/Bout", 16'(Bout), 16'd0);
      check("reset/Cout", 16'(Cout), 16'd0);
      drive(1'b1, 1'b1, 11, 22, 333);
      push("rst_edge", 0, 0, 0);
      tick;
      rst_n = 1'b1;

      // Load then MAC twice
      drive(1'b1, 1'b1, 3, -4, 100);
      push("load", 3, -4, 100);
      tick;
      drive(1'b1, 1'b0, 3, -4, 100);
      push("mac1", 3, -4, 88);
      tick;
      push("mac2", 3, -4, 76);
      tick;

      // Hold with en=0, both WrEn values
      drive(1'b1, 1'b1, 5, 7, -9);
      push("hold_load", 5, 7, -9);
      tick;
      drive(1'b0, 1'b0, -1, 2, 1234);
      push("hold_mac", 5, 7, -9);
      tick;
      drive(1'b0, 1'b1, -1, 2, 1234);
      push("hold_wr", 5, 7, -9);
      tick;

      // Overflow wrap
      drive(1'b1, 1'b1, -128, -128, 32767);
      push("wrap_load", -128, -128, 32767);
      tick;
      drive(1'b1, 1'b0, -128, -128, 32767);
      push("wrap_mac", -128, -128, -16385);
      tick;

      // Operand extremes
      drive(1'b1, 1'b1, -128, 127, 0);
      push("ext1_load", -128, 127, 0);
      tick;
      drive(1'b1, 1'b0, -128, 127, 0);
      push("ext1_mac", -128, 127, -16256);
      tick;
      drive(1'b1, 1'b1, 127, 127, 0);
      push("ext2_load", 127, 127, 0);
      tick;
      drive(1'b1, 1'b0, 127, 127, 0);
      push("ext2_mac", 127, 127, 16129);
      tick;

      // Asynchronous reset between edges discards the accumulator
      drive(1'b1, 1'b1, 5, -6, 1000);
      push("arst_load", 5, -6, 1000);
      tick;
      #2 rst_n = 1'b0;
      #1;
      check("arst_now/Aout", 16'(Aout), 16'd0);
      check("arst_now/Bout", 16'(Bout), 16'd0);
      check("arst_now/Cout", 16'(Cout), 16'd0);
      drive(1'b1, 1'b1, 9, 9, 9);
      push("arst_edge1", 0, 0, 0);
      tick;
      drive(1'b1, 1'b0, 9, 9, 9);
      push("arst_edge2", 0, 0, 0);
      tick;
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 9, 9, 9);
      push("arst_dis", 0, 0, 0);
      tick;
      drive(1'b1, 1'b0, 2, 3, 500);
      push("arst_first", 2, 3, 6);
      tick;

      // Randomized load + single MAC
      for (int i = 0; i < 256; i++) begin
         ai = int'($urandom_range(255)) - 128;
         bi = int'($urandom_range(255)) - 128;
         ci = int'($urandom_range(65535)) - 32768;
         drive(1'b1, 1'b1, ai, bi, ci);
         push("rnd_load", ai, bi, ci);
         tick;
         drive(1'b1, 1'b0, ai, bi, ci);
         push("rnd_mac", ai, bi, ai * bi + ci);
         tick;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
